// File: rtl/filter_pkg.sv
// filter_pkg: shared fixed-point formats, types, default coefficients
// and arithmetic helpers for the biquad filter.
//   Samples      : signed Q10.32 (42 bits)
//   Coefficients : signed Q1.31  (32 bits)
//   Accumulator  : signed 64 bits, aligned to Q10.32
package filter_pkg;

    localparam int unsigned WHOLE_BITS  = 10;
    localparam int unsigned FRAC_BITS   = 32;
    localparam int unsigned WIDTH       = 42;
    localparam int unsigned COEFF_WHOLE = 1;
    localparam int unsigned COEFF_FRACT = 31;
    localparam int unsigned ACC_WIDTH   = 64;

    localparam int unsigned COEFF_WIDTH = COEFF_WHOLE + COEFF_FRACT;
    // Full-width product and a sum of five products with growth headroom.
    localparam int unsigned PROD_WIDTH  = WIDTH + COEFF_WIDTH;
    localparam int unsigned SUM_WIDTH   = PROD_WIDTH + 3;

    typedef logic signed [WIDTH-1:0]       sample_t;
    typedef logic signed [COEFF_WIDTH-1:0] coeff_t;
    typedef logic signed [ACC_WIDTH-1:0]   acc_t;
    typedef logic signed [PROD_WIDTH-1:0]  prod_t;
    typedef logic signed [SUM_WIDTH-1:0]   sum_t;
    typedef logic signed [WHOLE_BITS-1:0]  whole_t;

    localparam coeff_t DEF_B0 = 32'sh2000_0000;  //  0.25
    localparam coeff_t DEF_B1 = 32'sh4000_0000;  //  0.5
    localparam coeff_t DEF_B2 = 32'sh2000_0000;  //  0.25
    localparam coeff_t DEF_A1 = 32'shC000_0000;  // -0.5
    localparam coeff_t DEF_A2 = 32'sh4000_0000;  //  0.5

    localparam sample_t SAMPLE_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam sample_t SAMPLE_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic {
        COEF_EMPTY  = 1'b0,
        COEF_LOADED = 1'b1
    } coef_state_e;

    function automatic prod_t mul(input sample_t s, input coeff_t c);
        return prod_t'(s) * prod_t'(c);
    endfunction

    // Clamp an aligned accumulator into the Q10.32 sample range.
    function automatic sample_t sat_sample(input acc_t a);
        sample_t r;
        if (a > acc_t'(SAMPLE_MAX)) begin
            r = SAMPLE_MAX;
        end else if (a < acc_t'(SAMPLE_MIN)) begin
            r = SAMPLE_MIN;
        end else begin
            r = sample_t'(a);
        end
        return r;
    endfunction

endpackage

// File: rtl/filter_biquad_core.sv
// biquad_core: direct-form-I biquad arithmetic and x/y history.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   en_i          : a registered sample is present on x_i this cycle
//   x_i           : current sample x[n], Q10.32
//   b0_i..a2_i    : coefficients, Q1.31
//   y_int_o       : floor of the most recent afinal (integer part)
// afinal (Q10.32) and y_n_o (64-bit accumulator) are internal nets.
module biquad_core
    import filter_pkg::*;
(
    input  logic    clk_i,
    input  logic    rst_ni,
    input  logic    en_i,
    input  sample_t x_i,
    input  coeff_t  b0_i,
    input  coeff_t  b1_i,
    input  coeff_t  b2_i,
    input  coeff_t  a1_i,
    input  coeff_t  a2_i,
    output whole_t  y_int_o
);

    sample_t x1_q, x2_q, y1_q, y2_q;
    sum_t    sum;
    acc_t    y_n_o;
    sample_t afinal;

    // Products are kept at full width and summed wider than 64 bits so
    // that full-scale inputs cannot overflow; after the >>>31 alignment
    // the result always fits the 64-bit accumulator.
    always_comb begin
        sum    = sum_t'(mul(x_i,  b0_i))
               + sum_t'(mul(x1_q, b1_i))
               + sum_t'(mul(x2_q, b2_i))
               - sum_t'(mul(y1_q, a1_i))
               - sum_t'(mul(y2_q, a2_i));
        y_n_o  = acc_t'(sum >>> COEFF_FRACT);
        afinal = sat_sample(y_n_o);
    end

    // Feedback uses the full-precision afinal, closed in a single cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            x1_q <= '0;
            x2_q <= '0;
            y1_q <= '0;
            y2_q <= '0;
        end else if (en_i) begin
            x1_q <= x_i;
            x2_q <= x1_q;
            y1_q <= afinal;
            y2_q <= y1_q;
        end
    end

    // Dropping the fraction of a two's-complement value is a floor.
    assign y_int_o = y1_q[WIDTH-1:FRAC_BITS];

endmodule

// File: rtl/filter_top.sv
// filter_top: 3-stage pipelined biquad filter for a 10-bit ADC stream.
//   clk                : rising-edge clock
//   reset              : asynchronous active-low reset
//   x_adc              : signed ADC sample
//   coefficients_ready : load coefficients (first assertion only)
//   sample_ready       : x_adc valid this cycle
//   y_n                : signed filtered sample
//   valid_out          : y_n updated this cycle
// Stage 1 registers the sample, stage 2 (biquad_core) updates history,
// stage 3 registers the integer output.
module filter_top
    import filter_pkg::*;
#(
    parameter coeff_t B0 = DEF_B0,
    parameter coeff_t B1 = DEF_B1,
    parameter coeff_t B2 = DEF_B2,
    parameter coeff_t A1 = DEF_A1,
    parameter coeff_t A2 = DEF_A2
)(
    input  logic                         clk,
    input  logic                         reset,
    input  logic signed [WHOLE_BITS-1:0] x_adc,
    input  logic                         coefficients_ready,
    input  logic                         sample_ready,
    output logic signed [WHOLE_BITS-1:0] y_n,
    output logic                         valid_out
);

    coef_state_e state_q, state_d;
    logic        load_en;
    logic        coeff_loaded;
    logic        accept;

    coeff_t  b0_q, b1_q, b2_q, a1_q, a2_q;
    sample_t x_q;
    logic    v1_q, v2_q;
    whole_t  y_int;
    whole_t  y_n_q;
    logic    valid_q;

    // Coefficients load once; later coefficients_ready pulses are ignored.
    always_comb begin
        state_d = state_q;
        load_en = 1'b0;
        case (state_q)
            COEF_EMPTY: begin
                if (coefficients_ready) begin
                    state_d = COEF_LOADED;
                    load_en = 1'b1;
                end
            end
            COEF_LOADED: state_d = COEF_LOADED;
            default:     state_d = COEF_EMPTY;
        endcase
    end

    assign coeff_loaded = (state_q == COEF_LOADED);
    assign accept       = sample_ready & coeff_loaded;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= COEF_EMPTY;
            b0_q    <= '0;
            b1_q    <= '0;
            b2_q    <= '0;
            a1_q    <= '0;
            a2_q    <= '0;
        end else begin
            state_q <= state_d;
            if (load_en) begin
                b0_q <= B0;
                b1_q <= B1;
                b2_q <= B2;
                a1_q <= A1;
                a2_q <= A2;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_q     <= '0;
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            y_n_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            if (accept) begin
                x_q <= {x_adc, {FRAC_BITS{1'b0}}};
            end
            v1_q    <= accept;
            v2_q    <= v1_q;
            valid_q <= v2_q;
            // afinal is already clamped to Q10.32, so its integer part is
            // inherently within [-512, 511]; no further clamp is needed.
            if (v2_q) begin
                y_n_q <= y_int;
            end
        end
    end

    biquad_core dut (
        .clk_i   (clk),
        .rst_ni  (reset),
        .en_i    (v1_q),
        .x_i     (x_q),
        .b0_i    (b0_q),
        .b1_i    (b1_q),
        .b2_i    (b2_q),
        .a1_i    (a1_q),
        .a2_i    (a2_q),
        .y_int_o (y_int)
    );

    assign y_n       = y_n_q;
    assign valid_out = valid_q;

endmodule

// File: tb/tb_filter_top.sv
`timescale 1ns/1ps
module tb_filter_top;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset;
    logic signed [9:0] x_adc, x_s;
    logic              cr, sr, cr_s, sr_s;
    logic signed [9:0] y_n, y_s;
    logic              valid_out, v_s;

    filter_top u_dut (
        .clk                (clk),
        .reset              (reset),
        .x_adc              (x_adc),
        .coefficients_ready (cr),
        .sample_ready       (sr),
        .y_n                (y_n),
        .valid_out          (valid_out)
    );

    filter_top #(
        .B0 (32'sh7FFF_FFFF),
        .B1 (32'sh7FFF_FFFF),
        .B2 (32'sh7FFF_FFFF),
        .A1 (32'sh0000_0000),
        .A2 (32'sh0000_0000)
    ) u_sat (
        .clk                (clk),
        .reset              (reset),
        .x_adc              (x_s),
        .coefficients_ready (cr_s),
        .sample_ready       (sr_s),
        .y_n                (y_s),
        .valid_out          (v_s)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    int unsigned cyc     = 0;
    bit          loaded  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: exact biquad in 128-bit integers, Q10.32 state.
    typedef logic signed [127:0] wide_t;
    localparam longint MB0 =  536870912;
    localparam longint MB1 = 1073741824;
    localparam longint MB2 =  536870912;
    localparam longint MA1 = -1073741824;
    localparam longint MA2 = 1073741824;
    wide_t m_x1, m_x2, m_y1, m_y2;

    function automatic void model_clear();
        m_x1 = '0; m_x2 = '0; m_y1 = '0; m_y2 = '0;
    endfunction

    function automatic int model_step(input int x);
        wide_t x0, acc, af, hi, lo;
        hi  = (wide_t'(1) <<< 41) - 1;
        lo  = -(wide_t'(1) <<< 41);
        x0  = wide_t'(x) <<< 32;
        acc = x0 * wide_t'(MB0) + m_x1 * wide_t'(MB1) + m_x2 * wide_t'(MB2)
            - m_y1 * wide_t'(MA1) - m_y2 * wide_t'(MA2);
        af  = acc >>> 31;
        if (af > hi) af = hi;
        if (af < lo) af = lo;
        m_x2 = m_x1; m_x1 = x0;
        m_y2 = m_y1; m_y1 = af;
        return int'(af >>> 32);
    endfunction

    typedef struct {
        int          y;
        int unsigned cyc;
    } sb_item_t;
    sb_item_t sb_q[$];

    // Scoreboard monitor: every valid_out must match the oldest pending
    // sample in value and arrival cycle; overdue samples are misses.
    always @(negedge clk) begin : monitor
        sb_item_t it;
        while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
            it = sb_q.pop_front();
            n_tests++;
            n_fail++;
            $display("FAIL sb_missing_valid: no valid_out at cycle %0d, required y_n=%0d", it.cyc, it.y);
        end
        if (valid_out === 1'b1) begin
            n_tests++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected_valid: valid_out=1 y_n=%0d at cycle %0d, required no output", y_n, cyc);
            end else begin
                it = sb_q.pop_front();
                if (y_n !== it.y || cyc !== it.cyc) begin
                    n_fail++;
                    $display("FAIL sb_sample: got y_n=%0d at cycle %0d, required y_n=%0d at cycle %0d", y_n, cyc, it.y, it.cyc);
                end
            end
        end
    end

    // Called just after a falling edge: drive one cycle of input.
    task automatic drive(input bit s, input int x, output int yexp);
        sb_item_t it;
        sr    = s;
        x_adc = x[9:0];
        yexp  = 0;
        if (s && loaded) begin
            yexp   = model_step(x);
            it.y   = yexp;
            it.cyc = cyc + 3;
            sb_q.push_back(it);
        end
    endtask

    task automatic idle(input int n);
        int d;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            drive(1'b0, 0, d);
        end
    endtask

    task automatic load_coeffs();
        @(negedge clk);
        cr = 1'b1;
        @(negedge clk);
        cr = 1'b0;
        loaded = 1'b1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        sr = 1'b0; cr = 1'b0; sr_s = 1'b0; cr_s = 1'b0; x_adc = '0; x_s = '0;
        #2 reset = 1'b0;
        sb_q.delete();
        model_clear();
        loaded = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        #7;
        n_tests++;
        if (y_n !== 10'sd0 || valid_out !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got y_n=%0d valid_out=%b, required 0/0", y_n, valid_out);
        end
        n_tests++;
        if (u_dut.dut.afinal !== 42'sd0) begin
            n_fail++;
            $display("FAIL reset_afinal: got %0d, required 0", u_dut.dut.afinal);
        end
    endtask

    // Samples before any coefficient load (including one alongside the
    // load pulse itself, and loads requested during reset) are ignored.
    task automatic test_no_coeff();
        int d;
        cr = 1'b1;
        repeat (2) @(negedge clk);
        cr = 1'b0;
        reset = 1'b1;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            if (j >= 3) begin
                n_tests++;
                if (valid_out !== 1'b0) begin
                    n_fail++;
                    $display("FAIL nocoeff_valid: got valid_out=%b at step %0d, required 0", valid_out, j);
                end
            end
            drive(1'b1, 100 + j, d);
        end
        @(negedge clk);
        cr = 1'b1;
        drive(1'b1, 300, d);
        @(negedge clk);
        cr = 1'b0;
        drive(1'b0, 0, d);
        loaded = 1'b1;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            n_tests++;
            if (valid_out !== 1'b0) begin
                n_fail++;
                $display("FAIL loadcycle_valid: got valid_out=%b at step %0d, required 0", valid_out, j);
            end
        end
    endtask

    task automatic test_impulse();
        int d, e;
        for (int j = 0; j < 150; j++) begin
            @(negedge clk);
            if (j >= 3) begin
                n_tests++;
                if (valid_out !== 1'b1) begin
                    n_fail++;
                    $display("FAIL impulse_valid: got valid_out=%b at step %0d, required 1", valid_out, j);
                end
            end
            if (j >= 3 && j <= 5) begin
                e = (j == 3) ? 127 : (j == 4) ? 319 : 223;
                n_tests++;
                if (y_n !== e) begin
                    n_fail++;
                    $display("FAIL impulse_value: got y_n=%0d at step %0d, required %0d", y_n, j, e);
                end
            end
            drive(1'b1, (j == 0) ? 511 : 0, d);
        end
        @(negedge clk);
        n_tests++;
        if (y_n !== 10'sd0) begin
            n_fail++;
            $display("FAIL impulse_decay: got y_n=%0d, required 0", y_n);
        end
        drive(1'b0, 0, d);
        idle(4);
    endtask

    task automatic test_reset_midstream();
        int d;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            drive(1'b1, (j == 0) ? 511 : 0, d);
        end
        #2 reset = 1'b0;
        sr = 1'b0;
        sb_q.delete();
        model_clear();
        loaded = 1'b0;
        #1;
        n_tests++;
        if (y_n !== 10'sd0 || valid_out !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got y_n=%0d valid_out=%b, required 0/0", y_n, valid_out);
        end
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            n_tests++;
            if (valid_out !== 1'b0) begin
                n_fail++;
                $display("FAIL midreset_hold: got valid_out=%b, required 0", valid_out);
            end
        end
        reset = 1'b1;
        load_coeffs();
        test_impulse();
    endtask

    task automatic test_step();
        int d, e;
        apply_reset();
        load_coeffs();
        for (int j = 0; j < 150; j++) begin
            @(negedge clk);
            if (j >= 3 && j <= 5) begin
                e = (j == 3) ? 25 : (j == 4) ? 87 : 131;
                n_tests++;
                if (y_n !== e) begin
                    n_fail++;
                    $display("FAIL step_value: got y_n=%0d at step %0d, required %0d", y_n, j, e);
                end
            end
            drive(1'b1, 100, d);
        end
        @(negedge clk);
        n_tests++;
        if (y_n !== 10'sd100) begin
            n_fail++;
            $display("FAIL step_settle: got y_n=%0d, required 100", y_n);
        end
        drive(1'b0, 0, d);
        idle(4);
    endtask

    task automatic test_gating();
        bit acc_hist [36];
        int exp_hist [36];
        int cur, x;
        bit s;
        apply_reset();
        load_coeffs();
        cur = 0;
        for (int j = 0; j < 36; j++) begin
            @(negedge clk);
            if (j >= 3) begin
                if (acc_hist[j-3]) cur = exp_hist[j-3];
                n_tests++;
                if (valid_out !== acc_hist[j-3]) begin
                    n_fail++;
                    $display("FAIL gate_valid: got valid_out=%b at step %0d, required %b", valid_out, j, acc_hist[j-3]);
                end
                n_tests++;
                if (y_n !== cur) begin
                    n_fail++;
                    $display("FAIL gate_hold: got y_n=%0d at step %0d, required %0d", y_n, j, cur);
                end
            end
            s = (j % 3 == 0) && (j < 30);
            x = int'($urandom_range(1023)) - 512;
            acc_hist[j] = s;
            drive(s, x, exp_hist[j]);
        end
        idle(2);
    endtask

    task automatic test_back_to_back_sine();
        int d, x;
        for (int j = 0; j < 200; j++) begin
            @(negedge clk);
            x = int'(511.0 * $sin(2.0 * 3.14159265358979 * 60.0 * j / 6000.0));
            drive(1'b1, x, d);
        end
        idle(5);
    endtask

    task automatic test_saturation();
        @(negedge clk);
        cr_s = 1'b1;
        @(negedge clk);
        cr_s = 1'b0;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            if (j == 3 || j == 4) begin
                n_tests++;
                if (y_s !== ((j == 3) ? 10'sd510 : 10'sd511) || v_s !== 1'b1) begin
                    n_fail++;
                    $display("FAIL sat_pos_ramp: got y_n=%0d valid=%b at step %0d, required %0d/1", y_s, v_s, j, (j == 3) ? 510 : 511);
                end
            end
            sr_s = 1'b1;
            x_s  = 10'sd511;
        end
        @(negedge clk);
        n_tests++;
        if (y_s !== 10'sd511 || u_sat.dut.afinal !== 42'sh1FF_FFFF_FFFF) begin
            n_fail++;
            $display("FAIL sat_pos: got y_n=%0d afinal=%h, required 511/1ffffffffff", y_s, u_sat.dut.afinal);
        end
        for (int j = 0; j < 10; j++) begin
            sr_s = 1'b1;
            x_s  = -10'sd512;
            @(negedge clk);
        end
        n_tests++;
        if (y_s !== -10'sd512 || v_s !== 1'b1 || u_sat.dut.afinal !== 42'sh200_0000_0000) begin
            n_fail++;
            $display("FAIL sat_neg: got y_n=%0d valid=%b afinal=%h, required -512/1/20000000000", y_s, v_s, u_sat.dut.afinal);
        end
        sr_s = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0;
        cr = 1'b0; sr = 1'b0; x_adc = '0;
        cr_s = 1'b0; sr_s = 1'b0; x_s = '0;
        model_clear();
        test_reset();
        test_no_coeff();
        test_impulse();
        test_reset_midstream();
        test_step();
        test_gating();
        test_back_to_back_sine();
        test_saturation();
        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_leftover: got %0d pending samples, required 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
